// File: rtl/multiplier_simd_pipe.sv
// Runtime-reconfigurable SIMD multiplier: 1x full, 2x half or 4x quarter lanes.
// Operands, mode and signedness ride a valid-tagged pipeline; multiply at the end.
module multiplier_simd_pipe #(
    parameter int IA_W   = 16,
    parameter int IB_W   = 16,
    parameter int STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_en_ff,
    input  logic                 i_valid,
    input  logic [1:0]           i_mode,
    input  logic                 i_signed,
    input  logic [IA_W-1:0]      i_a,
    input  logic [IB_W-1:0]      i_b,
    output logic                 o_valid,
    output logic [IA_W+IB_W-1:0] o_prod,
    output logic                 o_busy
);

    localparam int MUL_W = IA_W + IB_W;
    localparam int HA = IA_W / 2;
    localparam int HB = IB_W / 2;
    localparam int HP = MUL_W / 2;
    localparam int QA = IA_W / 4;
    localparam int QB = IB_W / 4;
    localparam int QP = MUL_W / 4;

    typedef struct packed {
        logic [1:0]      mode;
        logic            sgn;
        logic [IA_W-1:0] a;
        logic [IB_W-1:0] b;
    } op_t;

    // Each lane extends its own MSB to the lane product width, so no
    // carry or borrow can leak into a neighbouring lane.
    function automatic logic [MUL_W-1:0] simd_mul(input op_t op);
        logic [MUL_W-1:0] p;
        logic [MUL_W-1:0] fa, fb;
        logic [HA-1:0]    ha;
        logic [HB-1:0]    hb;
        logic [HP-1:0]    hax, hbx;
        logic [QA-1:0]    qa;
        logic [QB-1:0]    qb;
        logic [QP-1:0]    qax, qbx;
        p = '0;
        case (op.mode)
            2'd1: begin
                for (int k = 0; k < 2; k++) begin
                    ha  = op.a[k*HA +: HA];
                    hb  = op.b[k*HB +: HB];
                    hax = {{HB{op.sgn & ha[HA-1]}}, ha};
                    hbx = {{HA{op.sgn & hb[HB-1]}}, hb};
                    p[k*HP +: HP] = hax * hbx;
                end
            end
            2'd2: begin
                for (int k = 0; k < 4; k++) begin
                    qa  = op.a[k*QA +: QA];
                    qb  = op.b[k*QB +: QB];
                    qax = {{QB{op.sgn & qa[QA-1]}}, qa};
                    qbx = {{QA{op.sgn & qb[QB-1]}}, qb};
                    p[k*QP +: QP] = qax * qbx;
                end
            end
            default: begin
                fa = {{IB_W{op.sgn & op.a[IA_W-1]}}, op.a};
                fb = {{IA_W{op.sgn & op.b[IB_W-1]}}, op.b};
                p  = fa * fb;
            end
        endcase
        return p;
    endfunction

    op_t in_op;
    assign in_op = '{mode: i_mode, sgn: i_signed, a: i_a, b: i_b};

    generate
        if (STAGES == 0) begin : g_comb
            assign o_valid = i_valid;
            assign o_prod  = simd_mul(in_op);
            assign o_busy  = 1'b0;
        end else begin : g_pipe
            op_t               op_q [STAGES];
            logic [STAGES-1:0] vld_q;

            // Payload flops load only behind a valid bit, so bubbles leave
            // the last stage holding the previous result.
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    vld_q <= '0;
                    for (int n = 0; n < STAGES; n++) begin
                        op_q[n] <= '0;
                    end
                end else if (i_en_ff) begin
                    vld_q[0] <= i_valid;
                    if (i_valid) begin
                        op_q[0] <= in_op;
                    end
                    for (int n = 1; n < STAGES; n++) begin
                        vld_q[n] <= vld_q[n-1];
                        if (vld_q[n-1]) begin
                            op_q[n] <= op_q[n-1];
                        end
                    end
                end
            end

            assign o_valid = vld_q[STAGES-1];
            assign o_prod  = simd_mul(op_q[STAGES-1]);
            assign o_busy  = |vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_multiplier_simd_pipe.sv
// Scoreboard bench: three instances (STAGES 0, 2, 4) share one stimulus stream.
// Expected products and due cycles are queued per instance at issue time.
module tb_multiplier_simd_pipe;

    typedef struct {
        logic [31:0] prod;
        int          due;
    } exp_t;

    localparam int STG [3] = '{0, 2, 4};

    logic        clk;
    logic        rstn;
    logic        en;
    logic        valid;
    logic [1:0]  mode;
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic        vo [3];
    logic [31:0] po [3];
    logic        bo [3];

    exp_t        q [3][$];
    logic [31:0] last [3];
    int          en_cyc;
    int          n_cmp;
    int          n_bad;

    multiplier_simd_pipe #(.IA_W(16), .IB_W(16), .STAGES(0)) u_s0 (
        .i_clk(clk), .i_rstn(rstn), .i_en_ff(en), .i_valid(valid),
        .i_mode(mode), .i_signed(sgn), .i_a(a), .i_b(b),
        .o_valid(vo[0]), .o_prod(po[0]), .o_busy(bo[0])
    );
    multiplier_simd_pipe #(.IA_W(16), .IB_W(16), .STAGES(2)) u_s2 (
        .i_clk(clk), .i_rstn(rstn), .i_en_ff(en), .i_valid(valid),
        .i_mode(mode), .i_signed(sgn), .i_a(a), .i_b(b),
        .o_valid(vo[1]), .o_prod(po[1]), .o_busy(bo[1])
    );
    multiplier_simd_pipe #(.IA_W(16), .IB_W(16), .STAGES(4)) u_s4 (
        .i_clk(clk), .i_rstn(rstn), .i_en_ff(en), .i_valid(valid),
        .i_mode(mode), .i_signed(sgn), .i_a(a), .i_b(b),
        .o_valid(vo[2]), .o_prod(po[2]), .o_busy(bo[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en) en_cyc++;
    end

    // Monitor: a result is consumed on a cycle where o_valid is seen with
    // the enable high; between results the registered outputs must hold.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (!rstn) begin
                last[d] = '0;
            end else if (vo[d] && en) begin
                n_cmp++;
                if (q[d].size() == 0) begin
                    n_bad++;
                    $display("FAIL stray_valid S=%0d got %h, none expected",
                             STG[d], po[d]);
                end else begin
                    e = q[d].pop_front();
                    if (po[d] !== e.prod || en_cyc != e.due + STG[d]) begin
                        n_bad++;
                        $display("FAIL result S=%0d got %h @%0d want %h @%0d",
                                 STG[d], po[d], en_cyc, e.prod, e.due + STG[d]);
                    end
                end
                last[d] = po[d];
            end else if (d != 0 && !vo[d]) begin
                n_cmp++;
                if (po[d] !== last[d]) begin
                    n_bad++;
                    $display("FAIL hold S=%0d got %h want %h",
                             STG[d], po[d], last[d]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] m, input logic s,
                         input logic [15:0] xa, input logic [15:0] xb,
                         input logic [31:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        en    = 1'b1;
        valid = 1'b1;
        mode  = m;
        sgn   = s;
        a     = xa;
        b     = xb;
        e.prod = exp;
        e.due  = en_cyc;
        for (int d = 0; d < 3; d++) q[d].push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            en    = 1'b1;
            valid = 1'b0;
        end
    endtask

    task automatic chk_quiet(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_valid_S%0d", tag, STG[d]), {31'd0, vo[d]}, 32'd0);
            chk($sformatf("%s_busy_S%0d", tag, STG[d]), {31'd0, bo[d]}, 32'd0);
            if (d != 0) chk($sformatf("%s_prod_S%0d", tag, STG[d]), po[d], 32'd0);
        end
    endtask

    initial begin
        int t;
        n_cmp  = 0;
        n_bad  = 0;
        en_cyc = 0;
        rstn   = 1'b0;
        en     = 1'b0;
        valid  = 1'b0;
        mode   = 2'd0;
        sgn    = 1'b0;
        a      = '0;
        b      = '0;
        #12;
        chk_quiet("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);

        // Directed vectors, one at a time
        issue(2'd0, 1'b1, 16'hFFFF, 16'h0003, 32'hFFFFFFFD);
        idle(6);
        issue(2'd1, 1'b0, 16'hFF02, 16'h0203, 32'h01FE0006);
        idle(6);
        issue(2'd2, 1'b1, 16'hF321, 16'h2222, 32'hFE060402);
        idle(6);
        issue(2'd0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        issue(2'd0, 1'b1, 16'h8000, 16'h8000, 32'h40000000);
        issue(2'd1, 1'b1, 16'h80FF, 16'h80FF, 32'h40000001);
        issue(2'd2, 1'b0, 16'hFFFF, 16'hFFFF, 32'hE1E1E1E1);
        issue(2'd2, 1'b1, 16'h8888, 16'h7777, 32'hC8C8C8C8);
        issue(2'd3, 1'b1, 16'hFFFF, 16'h0003, 32'hFFFFFFFD);
        idle(6);

        // Back-to-back mixed modes
        issue(2'd0, 1'b1, 16'hFFFF, 16'h0003, 32'hFFFFFFFD);
        issue(2'd1, 1'b0, 16'hFF02, 16'h0203, 32'h01FE0006);
        issue(2'd2, 1'b1, 16'hF321, 16'h2222, 32'hFE060402);
        idle(8);

        // Stall for 3 cycles once the op sits in the first stage
        issue(2'd1, 1'b0, 16'hFF02, 16'h0203, 32'h01FE0006);
        @(posedge clk);
        #1;
        en    = 1'b0;
        valid = 1'b1;
        mode  = 2'd0;
        a     = 16'h1234;
        b     = 16'h5678;
        repeat (3) begin
            chk("stall_busy_S2", {31'd0, bo[1]}, 32'd1);
            chk("stall_busy_S4", {31'd0, bo[2]}, 32'd1);
            @(posedge clk);
            #1;
        end
        en    = 1'b1;
        valid = 1'b0;
        idle(8);

        // Async reset with two ops in flight
        issue(2'd2, 1'b1, 16'hF321, 16'h2222, 32'hFE060402);
        issue(2'd0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        @(posedge clk);
        #1;
        chk("preflush_busy_S4", {31'd0, bo[2]}, 32'd1);
        valid = 1'b0;
        rstn  = 1'b0;
        for (int d = 0; d < 3; d++) q[d].delete();
        #1;
        chk_quiet("midreset");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(8);
        issue(2'd1, 1'b1, 16'h80FF, 16'h80FF, 32'h40000001);
        idle(8);

        t = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 50) begin
            idle(1);
            t++;
        end
        n_cmp++;
        if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending want 0",
                     q[0].size() + q[1].size() + q[2].size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
